alu_rs_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the single-cycle ALU execute unit.
//  - Buffers dispatched ALU ops and captures operands from CDB broadcasts (wakeup).
//  - Selects the oldest op with both operands ready (select).
//  - Presents it through a registered issue stage to alu_unit.next_execute.
//  - Sits between rename/dispatch and alu_unit. Stalls when writeback deasserts issue_ready.

---
 rtl/alu_rs_scheduler_pkg.sv | 33 +++
 rtl/alu_rs_age_picker.sv | 27 ++
 rtl/alu_rs_scheduler.sv | 155 +++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types and constants for the ALU reservation station and its issue scheduler.
package alu_rs_scheduler_pkg;

    localparam int ALU_RS_DEPTH     = 8;
    localparam int ALU_RS_ROB_IDX_W = 5;

    typedef logic [ALU_RS_ROB_IDX_W-1:0] rs_tag_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        rs_tag_t     rob_idx;
    } rs_t;

    typedef struct packed {
        rs_t     op;
        logic    rs1_rdy;
        logic    rs2_rdy;
        rs_tag_t rs1_tag;
        rs_tag_t rs2_tag;
    } alu_rs_slot_t;

    function automatic logic tag_hit(input logic cdb_valid, input rs_tag_t cdb_tag,
                                     input rs_tag_t tag);
        return cdb_valid && (cdb_tag == tag);
    endfunction

endpackage

// File: rtl/alu_rs_age_picker.sv
// Oldest-first picker: grants the eligible entry that no other eligible entry is older than.
// age[i][j] = 1 means entry i is older than entry j.
module alu_rs_age_picker #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    input  logic [DEPTH-1:0]            eligible,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);

    logic [DEPTH-1:0] older;

    always_comb begin
        grant = '0;
        older = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older[j] = (j != i) && eligible[j] && age[j][i];
            end
            grant[i] = eligible[i] && !(|older);
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: dispatch buffering, CDB wakeup, oldest-ready select, registered issue.
// Optional ALU_RS_BYPASS_EN: a fully-ready dispatch goes straight to the issue reg when nothing older is eligible.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int DEPTH     = ALU_RS_DEPTH,
    parameter int ROB_IDX_W = ALU_RS_ROB_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  rs_t                       disp_entry,
    input  logic                      disp_rs1_rdy,
    input  logic                      disp_rs2_rdy,
    input  logic [ROB_IDX_W-1:0]      disp_rs1_tag,
    input  logic [ROB_IDX_W-1:0]      disp_rs2_tag,
    input  logic                      cdb_valid,
    input  logic [ROB_IDX_W-1:0]      cdb_rob_idx,
    input  logic [31:0]               cdb_data,
    output logic                      issue_valid,
    output rs_t                       issue_entry,
    input  logic                      issue_ready,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    alu_rs_slot_t                  slot_q [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0]   age_q;
    rs_t                           issue_q;
    logic [CNT_W-1:0]              occ_q;

    logic [DEPTH-1:0] slot_valid, eligible, grant;
    logic             any_elig;
    logic [IDX_W-1:0] grant_idx, free_idx;
    alu_rs_slot_t     disp_slot;
    logic             adv, disp_fire, issue_fire, bypass, write_rs;

    always_comb begin
        slot_valid = '0;
        eligible   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = slot_q[i].op.valid;
            eligible[i]   = slot_q[i].op.valid && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy;
        end
    end

    alu_rs_age_picker #(.DEPTH(DEPTH)) u_picker (
        .age      (age_q),
        .eligible (eligible),
        .grant    (grant),
        .any      (any_elig)
    );

    always_comb begin
        grant_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_valid[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // x0 sources are ready with zero regardless of tag; otherwise a same-edge CDB hit is captured
    always_comb begin
        disp_slot          = '0;
        disp_slot.op       = disp_entry;
        disp_slot.op.valid = 1'b1;
        disp_slot.rs1_tag  = disp_rs1_tag;
        disp_slot.rs2_tag  = disp_rs2_tag;
        if (disp_entry.rs1_addr == 5'd0) begin
            disp_slot.rs1_rdy     = 1'b1;
            disp_slot.op.rs1_data = '0;
        end else if (disp_rs1_rdy) begin
            disp_slot.rs1_rdy = 1'b1;
        end else if (tag_hit(cdb_valid, cdb_rob_idx, disp_rs1_tag)) begin
            disp_slot.rs1_rdy     = 1'b1;
            disp_slot.op.rs1_data = cdb_data;
        end
        if (disp_entry.rs2_addr == 5'd0) begin
            disp_slot.rs2_rdy     = 1'b1;
            disp_slot.op.rs2_data = '0;
        end else if (disp_rs2_rdy) begin
            disp_slot.rs2_rdy = 1'b1;
        end else if (tag_hit(cdb_valid, cdb_rob_idx, disp_rs2_tag)) begin
            disp_slot.rs2_rdy     = 1'b1;
            disp_slot.op.rs2_data = cdb_data;
        end
    end

    assign disp_ready = (occ_q != CNT_W'(DEPTH));
    assign adv        = !issue_q.valid || issue_ready;
    assign disp_fire  = disp_valid && disp_ready;
    assign issue_fire = adv && any_elig;
`ifdef ALU_RS_BYPASS_EN
    assign bypass     = adv && !any_elig && disp_fire && disp_slot.rs1_rdy && disp_slot.rs2_rdy;
`else
    assign bypass     = 1'b0;
`endif
    assign write_rs   = disp_fire && !bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            age_q   <= '0;
            issue_q <= '0;
            occ_q   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i].op.valid <= 1'b0;
            age_q         <= '0;
            issue_q.valid <= 1'b0;
            occ_q         <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_q[i].op.valid) begin
                    if (!slot_q[i].rs1_rdy && tag_hit(cdb_valid, cdb_rob_idx, slot_q[i].rs1_tag)) begin
                        slot_q[i].rs1_rdy     <= 1'b1;
                        slot_q[i].op.rs1_data <= cdb_data;
                    end
                    if (!slot_q[i].rs2_rdy && tag_hit(cdb_valid, cdb_rob_idx, slot_q[i].rs2_tag)) begin
                        slot_q[i].rs2_rdy     <= 1'b1;
                        slot_q[i].op.rs2_data <= cdb_data;
                    end
                end
            end
            if (issue_fire) begin
                slot_q[grant_idx].op.valid <= 1'b0;
                issue_q                    <= slot_q[grant_idx].op;
            end else if (bypass) begin
                issue_q <= disp_slot.op;
            end else if (adv) begin
                issue_q.valid <= 1'b0;
            end
            // new entry is younger than everything currently resident
            if (write_rs) begin
                slot_q[free_idx] <= disp_slot;
                age_q[free_idx]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (slot_valid[j]) age_q[j][free_idx] <= 1'b1;
                end
            end
            occ_q <= occ_q + CNT_W'(write_rs) - CNT_W'(issue_fire);
        end
    end

    assign issue_valid = issue_q.valid;
    assign issue_entry = issue_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: expected issues are queued at dispatch and checked at acceptance.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

`ifdef ALU_RS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst_n, flush;
    logic        disp_valid, disp_ready;
    rs_t         disp_entry;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    rs_tag_t     disp_rs1_tag, disp_rs2_tag;
    logic        cdb_valid;
    rs_tag_t     cdb_rob_idx;
    logic [31:0] cdb_data;
    logic        issue_valid;
    rs_t         issue_entry;
    logic        issue_ready;
    logic [3:0]  occupancy;

    int  vectors     = 0;
    int  miscompares = 0;
    rs_t exp_q[$];

    alu_rs_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_entry   (disp_entry),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .disp_rs1_tag (disp_rs1_tag),
        .disp_rs2_tag (disp_rs2_tag),
        .cdb_valid    (cdb_valid),
        .cdb_rob_idx  (cdb_rob_idx),
        .cdb_data     (cdb_data),
        .issue_valid  (issue_valid),
        .issue_entry  (issue_entry),
        .issue_ready  (issue_ready),
        .occupancy    (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

    // Acceptance monitor: an op is consumed at the edge where issue_valid & issue_ready
    always @(negedge clk) begin
        rs_t e;
        if (rst_n && !flush && issue_valid && issue_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_issue got rob=%0d expected none", issue_entry.rob_idx);
            end else begin
                e = exp_q.pop_front();
                if (issue_entry !== e) begin
                    miscompares++;
                    $display("FAIL issue_entry got %h expected %h", issue_entry, e);
                end
            end
        end
    end

    function automatic rs_t mk(input int rob, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d1, input logic [31:0] d2);
        rs_t e;
        e.valid    = 1'b0;
        e.alu_op   = 4'(rob);
        e.rd_addr  = 5'(rob + 1);
        e.rs1_addr = a1;
        e.rs2_addr = a2;
        e.rs1_data = d1;
        e.rs2_data = d2;
        e.rob_idx  = rs_tag_t'(rob);
        return e;
    endfunction

    function automatic rs_t expct(input rs_t e, input logic [31:0] d1, input logic [31:0] d2);
        rs_t r;
        r          = e;
        r.valid    = 1'b1;
        r.rs1_data = d1;
        r.rs2_data = d2;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input rs_t e, input logic r1, input logic r2,
                            input rs_tag_t t1, input rs_tag_t t2);
        disp_valid   = 1'b1;
        disp_entry   = e;
        disp_rs1_rdy = r1;
        disp_rs2_rdy = r2;
        disp_rs1_tag = t1;
        disp_rs2_tag = t2;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        ok = (exp_q.size() == 0);
        exp_q.delete();
    endtask

    task automatic test_reset();
        rs_t e;
        vectors++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got occ=%0d iv=%b expected 0/0", occupancy, issue_valid);
        end
        #8 rst_n = 1'b1;
        tick();
        vectors++;
        if (disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_disp_ready got %b expected 1", disp_ready);
        end
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            e = mk(i, 5'd1, 5'd2, 32'(i), 32'(i * 2));
            dispatch(e, 1'b1, 1'b1, '0, '0);
        end
        vectors++;
        if (issue_valid !== 1'b1 || occupancy !== 4'd3) begin
            miscompares++;
            $display("FAIL pre_reset got iv=%b occ=%0d expected 1/3", issue_valid, occupancy);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (occupancy !== 4'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_op got occ=%0d iv=%b expected 0/0", occupancy, issue_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        vectors++;
        if (disp_ready !== 1'b1 || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL post_reset got rdy=%b occ=%0d expected 1/0", disp_ready, occupancy);
        end
        exp_q.delete();
    endtask

    task automatic test_fill();
        rs_t e;
        bit  ok;
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = mk(20 + i, 5'd5, 5'd6, 32'h0, 32'h100 + 32'(i));
            dispatch(e, 1'b0, 1'b1, rs_tag_t'(3), '0);
            exp_q.push_back(expct(e, 32'h0000_BEEF, 32'h100 + 32'(i)));
        end
        vectors++;
        if (occupancy !== 4'd8 || disp_ready !== 1'b0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full got occ=%0d rdy=%b iv=%b expected 8/0/0", occupancy, disp_ready, issue_valid);
        end
        tick();
        tick();
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_no_issue got iv=%b expected 0", issue_valid);
        end
        cdb_valid = 1'b1; cdb_rob_idx = rs_tag_t'(3); cdb_data = 32'h0000_BEEF;
        tick();
        cdb_valid = 1'b0;
        // an issue fires this cycle, but a full RS still refuses dispatch
        vectors++;
        if (disp_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_no_credit got rdy=%b expected 0", disp_ready);
        end
        dispatch(mk(31, 5'd1, 5'd1, 32'h5, 32'h5), 1'b1, 1'b1, '0, '0);
        vectors++;
        if (occupancy !== 4'd7) begin
            miscompares++;
            $display("FAIL full_blocked_disp got occ=%0d expected 7", occupancy);
        end
        wait_drain(30, ok);
        vectors++;
        if (!ok || occupancy !== 4'd0 || disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drain got ok=%b occ=%0d rdy=%b expected 1/0/1", ok, occupancy, disp_ready);
        end
    endtask

    task automatic test_wakeup_order();
        rs_t a, b;
        bit  ok;
        issue_ready = 1'b1;
        a = mk(10, 5'd3, 5'd4, 32'h0, 32'hA2);
        b = mk(11, 5'd3, 5'd4, 32'h0, 32'hB2);
        dispatch(a, 1'b0, 1'b1, rs_tag_t'(3), '0);
        exp_q.push_back(expct(a, 32'h1234, 32'hA2));
        dispatch(b, 1'b0, 1'b1, rs_tag_t'(3), '0);
        exp_q.push_back(expct(b, 32'h1234, 32'hB2));
        cdb_valid = 1'b1; cdb_rob_idx = rs_tag_t'(3); cdb_data = 32'h1234;
        tick();
        cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_not_same_edge got iv=%b expected 0", issue_valid);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_entry.rob_idx !== rs_tag_t'(10) || issue_entry.rs1_data !== 32'h1234) begin
            miscompares++;
            $display("FAIL wake_first got iv=%b rob=%0d d1=%h expected 1/10/1234",
                     issue_valid, issue_entry.rob_idx, issue_entry.rs1_data);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_entry.rob_idx !== rs_tag_t'(11)) begin
            miscompares++;
            $display("FAIL wake_second got iv=%b rob=%0d expected 1/11", issue_valid, issue_entry.rob_idx);
        end
        wait_drain(5, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wake_drain got pending expected empty");
        end
    endtask

    task automatic test_stall();
        rs_t c, d, e;
        rs_t ec, ed, ee;
        c = mk(12, 5'd7, 5'd8, 32'hC1, 32'hC2);
        d = mk(13, 5'd7, 5'd8, 32'hD1, 32'hD2);
        e = mk(14, 5'd7, 5'd8, 32'hE1, 32'hE2);
        ec = expct(c, 32'hC1, 32'hC2);
        ed = expct(d, 32'hD1, 32'hD2);
        ee = expct(e, 32'hE1, 32'hE2);
        issue_ready = 1'b0;
        dispatch(c, 1'b1, 1'b1, '0, '0); exp_q.push_back(ec);
        dispatch(d, 1'b1, 1'b1, '0, '0); exp_q.push_back(ed);
        dispatch(e, 1'b1, 1'b1, '0, '0); exp_q.push_back(ee);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (issue_entry !== ec || occupancy !== 4'd2) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got rob=%0d occ=%0d expected 12/2", k, issue_entry.rob_idx, occupancy);
            end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        vectors++;
        if (issue_entry !== ed || occupancy !== 4'd1) begin
            miscompares++;
            $display("FAIL stall_rel1 got rob=%0d occ=%0d expected 13/1", issue_entry.rob_idx, occupancy);
        end
        tick();
        vectors++;
        if (issue_entry !== ee || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL stall_rel2 got rob=%0d occ=%0d expected 14/0", issue_entry.rob_idx, occupancy);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_empty got iv=%b pending=%0d expected 0/0", issue_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_same_cycle();
        rs_t f, g;
        bit  ok;
        issue_ready = 1'b1;
        f = mk(15, 5'd6, 5'd7, 32'h11, 32'h0);
        cdb_valid = 1'b1; cdb_rob_idx = rs_tag_t'(7); cdb_data = 32'hDEAD;
        exp_q.push_back(expct(f, 32'h11, 32'hDEAD));
        dispatch(f, 1'b1, 1'b0, '0, rs_tag_t'(7));
        cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== BYP) begin
            miscompares++;
            $display("FAIL capture_lat1 got iv=%b expected %b", issue_valid, BYP);
        end
        tick();
        vectors++;
        if (issue_valid !== !BYP) begin
            miscompares++;
            $display("FAIL capture_lat2 got iv=%b expected %b", issue_valid, !BYP);
        end
        wait_drain(5, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL capture_drain got pending expected empty");
        end
        g = mk(16, 5'd0, 5'd8, 32'hFFFF_FFFF, 32'h22);
        exp_q.push_back(expct(g, 32'h0, 32'h22));
        dispatch(g, 1'b0, 1'b1, rs_tag_t'(9), '0);
        wait_drain(5, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL x0_ready got pending expected empty");
        end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        dispatch(mk(17, 5'd1, 5'd2, 32'h1, 32'h2), 1'b1, 1'b1, '0, '0);
        dispatch(mk(18, 5'd1, 5'd2, 32'h0, 32'h2), 1'b0, 1'b1, rs_tag_t'(4), '0);
        dispatch(mk(19, 5'd1, 5'd2, 32'h0, 32'h2), 1'b0, 1'b1, rs_tag_t'(4), '0);
        vectors++;
        if (issue_valid !== 1'b1 || occupancy !== 4'd2) begin
            miscompares++;
            $display("FAIL pre_flush got iv=%b occ=%0d expected 1/2", issue_valid, occupancy);
        end
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_rob_idx = rs_tag_t'(4); cdb_data = 32'h77;
        dispatch(mk(20, 5'd1, 5'd2, 32'h3, 32'h4), 1'b1, 1'b1, '0, '0);
        flush = 1'b0;
        cdb_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL flush got iv=%b occ=%0d expected 0/0", issue_valid, occupancy);
        end
        issue_ready = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_lost got iv=%b occ=%0d expected 0/0", issue_valid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        rs_t e;
        bit  ok;
        issue_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = mk(40 + i, 5'd9, 5'd10, 32'(i), ~32'(i));
            exp_q.push_back(expct(e, 32'(i), ~32'(i)));
            dispatch(e, 1'b1, 1'b1, '0, '0);
        end
        vectors++;
        if (occupancy !== (BYP ? 4'd0 : 4'd1)) begin
            miscompares++;
            $display("FAIL b2b_occ got %0d expected %0d", occupancy, BYP ? 0 : 1);
        end
        wait_drain(10, ok);
        vectors++;
        if (!ok || occupancy !== 4'd0) begin
            miscompares++;
            $display("FAIL b2b_drain got ok=%b occ=%0d expected 1/0", ok, occupancy);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        disp_valid   = 1'b0;
        disp_entry   = '0;
        disp_rs1_rdy = 1'b0;
        disp_rs2_rdy = 1'b0;
        disp_rs1_tag = '0;
        disp_rs2_tag = '0;
        cdb_valid    = 1'b0;
        cdb_rob_idx  = '0;
        cdb_data     = '0;
        issue_ready  = 1'b0;
        #3;
        test_reset();
        test_fill();
        test_wakeup_order();
        test_stall();
        test_same_cycle();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
